// File: rtl/bus_arb_mux_if.sv
// Bus bundle for bus_arb_mux: source data/requests and control in,
// registered bus value and ownership status out.
interface bus_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = 5
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_req;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic                  sel_valid;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic [SELW-1:0]       owner;

  // Side that supplies sources and control and observes the bus
  modport master (
    output src_data, src_req, mode, sel, sel_valid,
    input  bus_out, bus_valid, grant, owner
  );

  // Side implemented by the multiplexer/arbiter
  modport slave (
    input  src_data, src_req, mode, sel, sel_valid,
    output bus_out, bus_valid, grant, owner
  );
endinterface

// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer with two modes: direct select by the control
// unit, or round-robin arbitration with a bounded hold time under contention.
module bus_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 24,
  parameter int SELW     = 5,
  parameter int MAX_HOLD = 4
) (
  input logic         clk,
  input logic         clr,
  bus_arb_mux_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t state, state_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [SELW-1:0] last, last_nxt;

  logic [WIDTH-1:0] bus_out_q, bus_out_nxt;
  logic             bus_valid_q, valid_nxt;
  logic [NSRC-1:0]  grant_q, grant_nxt;
  logic [SELW-1:0]  owner_q, owner_nxt;

  logic [SELW-1:0] drive_idx;
  logic [NSRC-1:0] cand;
  logic            found;
  logic [SELW-1:0] winner;

  // Round-robin search: the current owner is masked out so "found" means
  // some other source wants the bus; the scan starts just after last.
  always_comb begin
    cand   = bus.src_req;
    found  = 1'b0;
    winner = '0;
    if (state == OWN) cand[owner_q] = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      if (!found && cand[(int'(last) + k) % NSRC]) begin
        found  = 1'b1;
        winner = SELW'((int'(last) + k) % NSRC);
      end
    end
  end

  // Next-state logic: decides who drives the bus after this edge.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    valid_nxt = 1'b0;
    drive_idx = '0;
    if (!bus.mode) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      if (bus.sel_valid && (int'(bus.sel) < NSRC)) begin
        valid_nxt = 1'b1;
        drive_idx = bus.sel;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state_nxt = OWN;
            valid_nxt = 1'b1;
            drive_idx = winner;
            hold_nxt  = HW'(1);
            last_nxt  = winner;
          end
        end
        OWN: begin
          if (bus.src_req[owner_q] && ((hold_cnt < HOLD_MAX) || !found)) begin
            valid_nxt = 1'b1;
            drive_idx = owner_q;
            if (hold_cnt < HOLD_MAX) hold_nxt = hold_cnt + HW'(1);
          end else if (found) begin
            valid_nxt = 1'b1;
            drive_idx = winner;
            hold_nxt  = HW'(1);
            last_nxt  = winner;
          end else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Output logic: next registered bus value, one-hot grant and owner index.
  always_comb begin
    bus_out_nxt = '0;
    grant_nxt   = '0;
    owner_nxt   = '0;
    if (valid_nxt) begin
      bus_out_nxt          = bus.src_data[int'(drive_idx) * WIDTH +: WIDTH];
      grant_nxt[drive_idx] = 1'b1;
      owner_nxt            = drive_idx;
    end
  end

  // State register: FSM, hold counter, round-robin pointer and bus outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last        <= SELW'(NSRC - 1);
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      owner_q     <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      last        <= last_nxt;
      bus_out_q   <= bus_out_nxt;
      bus_valid_q <= valid_nxt;
      grant_q     <= grant_nxt;
      owner_q     <= owner_nxt;
    end
  end

  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: hand-derived vector table, directed
// corner-case sequences, and randomized traffic against a behavioural model.
module tb_bus_arb_mux;

  localparam int WIDTH    = 32;
  localparam int NSRC     = 24;
  localparam int SELW     = 5;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic clr;

  bus_arb_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus_if();

  bus_arb_mux #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus_if)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  typedef struct {
    logic             mode;
    logic [SELW-1:0]  sel;
    logic             sel_valid;
    logic [NSRC-1:0]  req;
    logic [WIDTH-1:0] exp_bus;
    logic             exp_valid;
    logic [SELW-1:0]  exp_owner;
  } vec_t;

  vec_t vecs [16];

  logic [WIDTH-1:0] src [NSRC];
  int assertions = 0;
  int failures   = 0;

  int m_own, m_hold, m_last, m_drive;
  logic [WIDTH-1:0] e_bus;
  logic             e_valid;
  logic [NSRC-1:0]  e_grant;
  logic [SELW-1:0]  e_owner;

  logic [NSRC-1:0] req_all;
  logic [NSRC-1:0] rreq;

  function automatic int pickWinner(input int from, input logic [NSRC-1:0] req, input int exclude);
    int best  = -1;
    int bestd = NSRC;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i] && i != exclude) begin
        int d;
        d = (i - from - 1 + 2 * NSRC) % NSRC;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic modelOutputs();
    e_bus   = '0;
    e_valid = 1'b0;
    e_grant = '0;
    e_owner = '0;
    if (m_drive >= 0) begin
      e_bus            = src[m_drive];
      e_valid          = 1'b1;
      e_grant[m_drive] = 1'b1;
      e_owner          = SELW'(m_drive);
    end
  endtask

  task automatic modelReset();
    m_own   = -1;
    m_hold  = 0;
    m_last  = NSRC - 1;
    m_drive = -1;
    modelOutputs();
  endtask

  task automatic modelStep(input logic mode_i, input int sel_i, input logic sv_i,
                           input logic [NSRC-1:0] req_i);
    int w;
    int o;
    if (!mode_i) begin
      m_own   = -1;
      m_hold  = 0;
      m_drive = (sv_i && sel_i < NSRC) ? sel_i : -1;
    end else begin
      if (m_own < 0) begin
        w = pickWinner(m_last, req_i, -1);
        if (w >= 0) begin
          m_own = w; m_hold = 1; m_last = w;
        end
      end else begin
        o = m_own;
        w = pickWinner(o, req_i, o);
        if (req_i[o] && (m_hold < MAX_HOLD || w < 0)) begin
          m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
        end else if (w >= 0) begin
          m_own = w; m_hold = 1; m_last = w;
        end else begin
          m_own = -1; m_hold = 0;
        end
      end
      m_drive = m_own;
    end
    modelOutputs();
  endtask

  task automatic loadSources();
    for (int i = 0; i < NSRC; i++) bus_if.src_data[i*WIDTH +: WIDTH] = src[i];
  endtask

  // Drive one cycle of inputs at the falling edge, step the model on the
  // rising edge, and return at the next falling edge for sampling.
  task automatic applyStimulus(input logic mode_i, input int sel_i, input logic sv_i,
                               input logic [NSRC-1:0] req_i);
    bus_if.mode      = mode_i;
    bus_if.sel       = SELW'(sel_i);
    bus_if.sel_valid = sv_i;
    bus_if.src_req   = req_i;
    loadSources();
    @(posedge clk);
    modelStep(mode_i, sel_i, sv_i, req_i);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] xb, input logic xv,
                             input logic [NSRC-1:0] xg, input logic [SELW-1:0] xo);
    assertions++;
    if (bus_if.bus_out !== xb || bus_if.bus_valid !== xv ||
        bus_if.grant !== xg || bus_if.owner !== xo) begin
      failures++;
      $display("[TB] FAIL %s: got bus_out=%h valid=%b grant=%h owner=%0d, expected bus_out=%h valid=%b grant=%h owner=%0d",
               name, bus_if.bus_out, bus_if.bus_valid, bus_if.grant, bus_if.owner,
               xb, xv, xg, xo);
    end
  endtask

  task automatic checkConst(input string name, input logic [WIDTH-1:0] xb, input logic xv,
                            input int xo);
    logic [NSRC-1:0] g;
    g = '0;
    if (xv) g[xo] = 1'b1;
    checkOutput(name, xb, xv, g, xv ? SELW'(xo) : '0);
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, e_bus, e_valid, e_grant, e_owner);
  endtask

  task automatic checkInvariant(input string name);
    logic ok;
    assertions++;
    ok = $onehot0(bus_if.grant);
    if (bus_if.bus_valid)
      ok = ok && (int'(bus_if.owner) < NSRC) && (bus_if.grant[bus_if.owner] === 1'b1);
    else
      ok = ok && (bus_if.grant == '0) && (bus_if.owner == '0);
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s: got grant=%h owner=%0d valid=%b, expected one-hot grant matching owner",
               name, bus_if.grant, bus_if.owner, bus_if.bus_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) src[i] = 32'hDEAD0000 + WIDTH'(i);
    src[21] = 32'h12345678;
    req_all = '1;

    vecs[0]  = '{1'b0, 5'd21, 1'b1, '0,      32'h12345678, 1'b1, 5'd21};
    vecs[1]  = '{1'b0, 5'd26, 1'b1, '0,      32'h0,        1'b0, 5'd0};
    vecs[2]  = '{1'b0, 5'd0,  1'b1, '0,      32'hDEAD0000, 1'b1, 5'd0};
    vecs[3]  = '{1'b0, 5'd23, 1'b1, '0,      32'hDEAD0017, 1'b1, 5'd23};
    vecs[4]  = '{1'b0, 5'd24, 1'b1, '0,      32'h0,        1'b0, 5'd0};
    vecs[5]  = '{1'b0, 5'd5,  1'b0, '0,      32'h0,        1'b0, 5'd0};
    vecs[6]  = '{1'b0, 5'd31, 1'b1, '1,      32'h0,        1'b0, 5'd0};
    for (int i = 7; i < 11; i++)
      vecs[i] = '{1'b1, 5'd0, 1'b0, 24'h000088, 32'hDEAD0003, 1'b1, 5'd3};
    for (int i = 11; i < 15; i++)
      vecs[i] = '{1'b1, 5'd0, 1'b0, 24'h000088, 32'hDEAD0007, 1'b1, 5'd7};
    vecs[15] = '{1'b1, 5'd0, 1'b0, 24'h000088, 32'hDEAD0003, 1'b1, 5'd3};

    // Reset held with arbitration enabled and every source requesting
    clr              = 1'b0;
    bus_if.mode      = 1'b1;
    bus_if.sel       = '0;
    bus_if.sel_valid = 1'b0;
    bus_if.src_req   = req_all;
    loadSources();
    modelReset();
    repeat (3) @(negedge clk);
    checkConst("reset_hold", 32'h0, 1'b0, 0);

    clr = 1'b1;
    applyStimulus(1'b1, 0, 1'b0, req_all);
    checkConst("reset_release_first_grant", 32'hDEAD0000, 1'b1, 0);

    // Direct select rows, then hold-limit rotation between sources 3 and 7
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].mode, int'(vecs[i].sel), vecs[i].sel_valid, vecs[i].req);
      checkConst($sformatf("vec%0d", i), vecs[i].exp_bus, vecs[i].exp_valid, int'(vecs[i].exp_owner));
    end

    // Early release: owner 3 drops after its second cycle, 7 takes over at once
    applyStimulus(1'b1, 0, 1'b0, 24'h000088);
    checkConst("early_rel_hold", 32'hDEAD0003, 1'b1, 3);
    applyStimulus(1'b1, 0, 1'b0, 24'h000080);
    checkConst("early_rel_handover", 32'hDEAD0007, 1'b1, 7);
    applyStimulus(1'b1, 0, 1'b0, 24'h000000);
    checkConst("early_rel_idle", 32'h0, 1'b0, 0);

    // Wrap-around: after granting 23, source 0 beats source 22
    applyStimulus(1'b1, 0, 1'b0, 24'h800000);
    checkConst("wrap_grant23", 32'hDEAD0017, 1'b1, 23);
    applyStimulus(1'b1, 0, 1'b0, 24'h400001);
    checkConst("wrap_to0", 32'hDEAD0000, 1'b1, 0);

    // Lone requester keeps the bus indefinitely; hold counter saturates
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 0, 1'b0, 24'h000020);
      checkConst($sformatf("lone5_c%0d", i), 32'hDEAD0005, 1'b1, 5);
    end
    assertions++;
    if (int'(dut.hold_cnt) != MAX_HOLD) begin
      failures++;
      $display("[TB] FAIL hold_saturate: got hold_cnt=%0d, expected %0d", dut.hold_cnt, MAX_HOLD);
    end

    // Mode switch while source 9 owns drops ownership at that edge
    applyStimulus(1'b1, 0, 1'b0, 24'h000200);
    checkConst("own9", 32'hDEAD0009, 1'b1, 9);
    applyStimulus(1'b0, 9, 1'b0, 24'h000200);
    checkConst("mode_switch_off", 32'h0, 1'b0, 0);

    // Asynchronous reset in mid-cycle while owning
    applyStimulus(1'b1, 0, 1'b0, 24'h000200);
    checkConst("own9_again", 32'hDEAD0009, 1'b1, 9);
    #2 clr = 1'b0;
    #1 checkConst("async_clr", 32'h0, 1'b0, 0);
    modelReset();
    @(negedge clk);
    clr = 1'b1;
    applyStimulus(1'b1, 0, 1'b0, 24'h020204);
    checkConst("post_reset_lowest", 32'hDEAD0002, 1'b1, 2);

    // Randomized traffic against the behavioural model
    rreq = '0;
    for (int c = 0; c < 400; c++) begin
      logic m;
      int   s;
      logic sv;
      for (int i = 0; i < NSRC; i++) src[i] = $urandom;
      m  = ($urandom_range(0, 9) != 0);
      s  = $urandom_range(0, 31);
      sv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        rreq = NSRC'($urandom & $urandom & $urandom);
      applyStimulus(m, s, sv, rreq);
      checkModel($sformatf("rand_c%0d", c));
      checkInvariant($sformatf("rand_inv_c%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
